// File: rtl/color_select.sv
// -----------------------------------------------------------------------------
// color_select
//   Button-driven palette selector for the VGA pattern generator. Each raw
//   button goes through a 2-FF synchroniser and a counter debouncer. A rising
//   edge of the accepted level is one step: NEXT moves the palette index up,
//   PREV moves it down, and both wrap at NCOLORS. The index, its 12-bit RGB
//   colour and a one-cycle change strobe are registered together.
//
//   Optional feature (macro COLOR_SELECT_AUTOREPEAT_EN): a held button
//   auto-repeats after REPEAT_DELAY cycles, then every REPEAT_RATE cycles.
//
// Ports
//   CLK50MHZ   in   system clock, rising edge
//   RST        in   asynchronous active-low reset
//   BTN_NEXT   in   raw push-button, high = pressed
//   BTN_PREV   in   raw push-button, high = pressed
//   COLOR_IDX  out  [2:0] current palette index
//   COLOR_R/G/B out [3:0] current colour components
//   COLOR_STB  out  one-cycle pulse when index/colour change
// -----------------------------------------------------------------------------
module color_select #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int NCOLORS         = 8,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_RATE     = 10_000_000
) (
   input  logic       CLK50MHZ,
   input  logic       RST,
   input  logic       BTN_NEXT,
   input  logic       BTN_PREV,
   output logic [2:0] COLOR_IDX,
   output logic [3:0] COLOR_R,
   output logic [3:0] COLOR_G,
   output logic [3:0] COLOR_B,
   output logic       COLOR_STB
);

   // Elaboration-time guard against out-of-range configuration.
   if (DEBOUNCE_CYCLES < 2 || NCOLORS < 2 || NCOLORS > 8 ||
       REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
      $error("color_select: parameter out of range");
   end

   localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [2:0]     IDX_MAX = 3'(NCOLORS - 1);

   // Bit 0 = NEXT, bit 1 = PREV throughout.
   logic [1:0]      raw;
   logic [1:0]      sync1, sync2;
   logic [1:0]      accepted, accepted_d;
   logic [DB_W-1:0] db_cnt [2];
   logic [1:0]      rise;
   logic [1:0]      step;

   assign raw = {BTN_PREV, BTN_NEXT};

   // Synchronise and debounce. The accepted level flips on the
   // DEBOUNCE_CYCLES-th consecutive cycle the synchronised level differs.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge CLK50MHZ or negedge RST) begin
      if (!RST) begin
         sync1      <= '0;
         sync2      <= '0;
         accepted   <= '0;
         accepted_d <= '0;
         db_cnt[0]  <= '0;
         db_cnt[1]  <= '0;
      end else begin
         sync1      <= raw;
         sync2      <= sync1;
         accepted_d <= accepted;
         for (int b = 0; b < 2; b++) begin
            if (sync2[b] == accepted[b]) begin
               db_cnt[b] <= '0;
            end else if (db_cnt[b] == DB_LAST) begin
               accepted[b] <= ~accepted[b];
               db_cnt[b]   <= '0;
            end else begin
               db_cnt[b] <= db_cnt[b] + 1'b1;
            end
         end
      end
   end

   // Press only; a release produces no step.
   assign rise = accepted & ~accepted_d;

`ifdef COLOR_SELECT_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RCNT_W  = $clog2(RPT_MAX + 1);
   localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

   rep_state_t        rep_q [2];
   rep_state_t        rep_d [2];
   logic [RCNT_W-1:0] rcnt_q [2];
   logic [RCNT_W-1:0] rcnt_d [2];
   logic [1:0]        rep_step;

   always_ff @(posedge CLK50MHZ or negedge RST) begin
      if (!RST) begin
         for (int b = 0; b < 2; b++) begin
            rep_q[b]  <= IDLE;
            rcnt_q[b] <= '0;
         end
      end else begin
         for (int b = 0; b < 2; b++) begin
            rep_q[b]  <= rep_d[b];
            rcnt_q[b] <= rcnt_d[b];
         end
      end
   end

   // Counter value c during a cycle means c+1 cycles since entry, so the
   // repeat step lands exactly REPEAT_DELAY / REPEAT_RATE edges after the
   // previous step.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         rep_d[b]    = rep_q[b];
         rcnt_d[b]   = rcnt_q[b] + 1'b1;
         rep_step[b] = 1'b0;
         case (rep_q[b])
            IDLE: begin
               rcnt_d[b] = '0;
               if (rise[b]) rep_d[b] = DELAY;
            end
            DELAY: begin
               if (rcnt_q[b] == DELAY_LAST) begin
                  rep_step[b] = 1'b1;
                  rep_d[b]    = REPEAT;
                  rcnt_d[b]   = '0;
               end
            end
            REPEAT: begin
               if (rcnt_q[b] == RATE_LAST) begin
                  rep_step[b] = 1'b1;
                  rcnt_d[b]   = '0;
               end
            end
            default: begin
               rep_d[b]  = IDLE;
               rcnt_d[b] = '0;
            end
         endcase
         if (!accepted[b]) begin
            rep_d[b]    = IDLE;
            rcnt_d[b]   = '0;
            rep_step[b] = 1'b0;
         end
      end
   end

   // With both buttons held the repeat steps are masked; counters run on.
   assign step = rise | (rep_step & {2{~&accepted}});
`else
   assign step = rise;
`endif

   function automatic logic [11:0] palette(input logic [2:0] idx);
      case (idx)
         3'd0:    palette = 12'h000;
         3'd1:    palette = 12'hF00;
         3'd2:    palette = 12'h0F0;
         3'd3:    palette = 12'h00F;
         3'd4:    palette = 12'hFF0;
         3'd5:    palette = 12'h0FF;
         3'd6:    palette = 12'hF0F;
         default: palette = 12'hFFF;
      endcase
   endfunction

   logic [2:0] idx_next;
   logic       change;

   // Opposing steps in the same cycle cancel.
   always_comb begin
      idx_next = COLOR_IDX;
      change   = 1'b0;
      if (step[0] && !step[1]) begin
         idx_next = (COLOR_IDX == IDX_MAX) ? 3'd0 : COLOR_IDX + 3'd1;
         change   = 1'b1;
      end else if (step[1] && !step[0]) begin
         idx_next = (COLOR_IDX == 3'd0) ? IDX_MAX : COLOR_IDX - 3'd1;
         change   = 1'b1;
      end
   end

   always_ff @(posedge CLK50MHZ or negedge RST) begin
      if (!RST) begin
         COLOR_IDX <= '0;
         COLOR_R   <= '0;
         COLOR_G   <= '0;
         COLOR_B   <= '0;
         COLOR_STB <= 1'b0;
      end else begin
         COLOR_IDX                   <= idx_next;
         {COLOR_R, COLOR_G, COLOR_B} <= palette(idx_next);
         COLOR_STB                   <= change;
      end
   end

endmodule

// File: tb/tb_color_select.sv
// -----------------------------------------------------------------------------
// tb_color_select
//   Scoreboard bench for color_select with DEBOUNCE_CYCLES=4, NCOLORS=8,
//   REPEAT_DELAY=20, REPEAT_RATE=8. Stimulus pushes the expected index, colour
//   and strobe edge; a monitor pops one entry on every COLOR_STB.
//   Define COLOR_SELECT_AUTOREPEAT_EN for both files to cover auto-repeat.
// -----------------------------------------------------------------------------
module tb_color_select;

   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RR = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_next, btn_prev;
   logic [2:0] color_idx;
   logic [3:0] color_r, color_g, color_b;
   logic       color_stb;

   color_select #(
      .DEBOUNCE_CYCLES(DB),
      .NCOLORS        (8),
      .REPEAT_DELAY   (RD),
      .REPEAT_RATE    (RR)
   ) dut (
      .CLK50MHZ (clk),
      .RST      (rst_n),
      .BTN_NEXT (btn_next),
      .BTN_PREV (btn_prev),
      .COLOR_IDX(color_idx),
      .COLOR_R  (color_r),
      .COLOR_G  (color_g),
      .COLOR_B  (color_b),
      .COLOR_STB(color_stb)
   );

   always #10 clk = ~clk;

   // Edge counter: after posedge n, cyc == n when read on the next negedge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int idx;
      int rgb;
      int edge_n;
   } exp_t;

   exp_t sb[$];
   int   pal[8] = '{'h000, 'hF00, 'h0F0, 'h00F, 'hFF0, 'h0FF, 'hF0F, 'hFFF};
   int   model_idx = 0;
   int   n_vec = 0;
   int   n_miss = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push_step(input int dir, input int edge_n);
      exp_t e;
      model_idx = (model_idx + dir + 8) % 8;
      e.idx     = model_idx;
      e.rgb     = pal[model_idx];
      e.edge_n  = edge_n;
      sb.push_back(e);
   endfunction

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (color_stb === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_stb", int'(color_stb), 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("stb_idx",  int'(color_idx), e.idx);
            check("stb_rgb",  int'({color_r, color_g, color_b}), e.rgb);
            check("stb_edge", cyc, e.edge_n);
         end
      end
   end

   // Raw level high for 'hold' sampling edges starting at edge k, then low.
   task automatic press(input logic n, input logic p, input int hold);
      int k;
      int e;
      int last_ok;
      @(negedge clk);
      btn_next = n;
      btn_prev = p;
      k = cyc + 1;
      if ((n ^ p) && hold >= DB) begin
         e = k + DB + 2;
         push_step(n ? 1 : -1, e);
`ifdef COLOR_SELECT_AUTOREPEAT_EN
         // Accepted level drops at edge k+hold+1+DB; a repeat step landing at
         // edge e needs the level still high in the cycle before it.
         last_ok = k + hold + DB + 1;
         e = e + RD;
         while (e <= last_ok) begin
            push_step(n ? 1 : -1, e);
            e = e + RR;
         end
`else
         last_ok = 0;
`endif
      end
      repeat (hold) @(negedge clk);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      repeat (DB + 12) @(negedge clk);
      check("pending_steps", sb.size(), 0);
      check("idx_after", int'(color_idx), model_idx);
      check("rgb_after", int'({color_r, color_g, color_b}), pal[model_idx]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r;
      rst_n    = 1'b0;
      btn_next = 1'b0;
      btn_prev = 1'b0;

      // Reset held with random button activity.
      repeat (20) begin
         @(negedge clk);
         check("rst_idx", int'(color_idx), 0);
         check("rst_rgb", int'({color_r, color_g, color_b}), 'h000);
         check("rst_stb", int'(color_stb), 0);
         btn_next = 1'($urandom);
         btn_prev = 1'($urandom);
      end
      @(negedge clk);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      rst_n    = 1'b1;
      model_idx = 0;
      repeat (10) @(negedge clk);
      check("post_rst_idx", int'(color_idx), 0);
      check("post_rst_rgb", int'({color_r, color_g, color_b}), 'h000);

      // Single NEXT press: idx 1 / F00 at edge k+6.
      press(1'b1, 1'b0, 10);

      // Up to 7, wrap to 0, PREV back to 7.
      repeat (6) press(1'b1, 1'b0, 10);
      check("idx_at_7", int'(color_idx), 7);
      press(1'b1, 1'b0, 10);
      check("idx_wrap_0", int'(color_idx), 0);
      press(1'b0, 1'b1, 10);
      check("idx_wrap_7", int'(color_idx), 7);

      // Short glitch and simultaneous presses: no change.
      press(1'b1, 1'b0, 3);
      press(1'b1, 1'b1, 10);

      // Reset in the middle of a debounce.
      @(negedge clk);
      btn_next = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_idx", int'(color_idx), 0);
      check("async_rst_rgb", int'({color_r, color_g, color_b}), 'h000);
      model_idx = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      r = cyc + 1;
      push_step(1, r + DB + 2);
      repeat (14) @(negedge clk);
      btn_next = 1'b0;
      repeat (DB + 12) @(negedge clk);
      check("pending_rst_press", sb.size(), 0);
      check("idx_rst_press", int'(color_idx), 1);

      // Long hold from index 0.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_idx = 0;
      press(1'b1, 1'b0, 50);
`ifdef COLOR_SELECT_AUTOREPEAT_EN
      check("hold_final_idx", int'(color_idx), 5);
`else
      check("hold_final_idx", int'(color_idx), 1);
`endif

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/color_select.md
# color_select

Upstream control stage for the VGA pattern generator. It takes the raw BTN_NEXT/BTN_PREV push-buttons and synchronises and debounces them. Each accepted press steps a colour index through a fixed palette. The block presents the selected 12-bit RGB colour, plus a change strobe, to the VGA output stage, which paints the visible area with it.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); minimum 2.
- NCOLORS, 8, number of palette entries in use, range 2..8; index wraps at NCOLORS-1.
- REPEAT_DELAY, 25_000_000, cycles from acceptance of a press to first auto-repeat step (only with COLOR_SELECT_AUTOREPEAT_EN).
- REPEAT_RATE, 10_000_000, cycles between subsequent auto-repeat steps (only with COLOR_SELECT_AUTOREPEAT_EN).
- CLK50MHZ  in  1  system clock, 50 MHz; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- BTN_NEXT  in  1  raw button, asynchronous, high = pressed.
- BTN_PREV  in  1  raw button, asynchronous, high = pressed.
- COLOR_IDX  out  3  current palette index.
- COLOR_R, COLOR_G, COLOR_B  out  4 each  current colour, registered.
- COLOR_STB  out  1  one-cycle pulse in the cycle COLOR_IDX/RGB take a new value.

## Operation
- Per button: 2-FF synchroniser, then debouncer holding an accepted level and a counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits.
  - Counter clears whenever the synchronised level equals the accepted level.
  - Otherwise the counter increments. At DEBOUNCE_CYCLES the accepted level flips and the counter clears.
- Step pulse: rising edge of the accepted level (0->1). A release produces no step.
- Index update, evaluated every cycle:
  - NEXT step alone: idx+1, wrapping NCOLORS-1 -> 0.
  - PREV step alone: idx-1, wrapping 0 -> NCOLORS-1.
  - Both steps in the same cycle: no change and no COLOR_STB.
- RGB registered from the palette lookup of the new index, in the same edge as COLOR_IDX. Palette index -> RGB hex:
  - 0 000, 1 F00, 2 0F0, 3 00F
  - 4 FF0, 5 0FF, 6 F0F, 7 FFF
- COLOR_STB is asserted only when the index actually changes. With NCOLORS=1-equivalent behaviour excluded, every single step changes it.
- Reset (RST=0, any time): all of the following clear immediately and asynchronously.
  - Synchronisers, accepted levels and counters clear; a pending press is discarded.
  - COLOR_IDX=0, RGB=000, COLOR_STB=0, repeat state IDLE.
  - A button still held after reset release is debounced from 0 and counts as a new press.

## Timing
- Raw edge sampled at clock edge k, then stable. Synchronised level is visible after edge k+1. Accepted level flips at edge k+1+DEBOUNCE_CYCLES.
- COLOR_IDX/RGB update and COLOR_STB=1 at edge k+2+DEBOUNCE_CYCLES. COLOR_STB drops at the following edge.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no step and no output change.
- Maximum step rate: one per press. There is no internal throttling beyond the debounce.

## Configuration
- COLOR_SELECT_AUTOREPEAT_EN defined: each button has a repeat FSM with states IDLE, DELAY, REPEAT and a shared-width cycle counter.
  - IDLE -> DELAY on step pulse, counter cleared.
  - DELAY -> REPEAT after REPEAT_DELAY cycles, issuing one extra step.
  - REPEAT issues a step every REPEAT_RATE cycles.
  - Any state -> IDLE when the accepted level goes 0.
  - While both accepted levels are 1, repeat steps are suppressed; counters keep running.
- COLOR_SELECT_AUTOREPEAT_EN undefined: no repeat logic. Holding a button yields exactly one step. REPEAT_* parameters are ignored.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, NCOLORS=8, REPEAT_DELAY=20, REPEAT_RATE=8.
- Reset: hold RST=0 with random button activity -> COLOR_IDX=0, RGB=000, COLOR_STB=0 throughout; release -> values unchanged until a press.
- Single NEXT press held 10 cycles, raw edge at edge k -> COLOR_IDX=1, RGB=F00 and COLOR_STB=1 exactly at edge k+6; STB low at k+7; release causes no change.
- Wrap: 7 NEXT presses from 0 -> idx 7, RGB FFF. One more NEXT -> idx 0, RGB 000. One PREV -> idx 7.
- Glitch: NEXT high for 3 cycles -> no STB, idx unchanged. Simultaneous NEXT+PREV raw edges held 10 cycles -> no STB, idx unchanged.
- Reset mid-debounce: NEXT raw high, RST pulsed low 2 cycles later, NEXT kept high -> no step before reset; one step 6 edges after reset release edge.
- Auto-repeat: NEXT held 50 cycles.
  - Macro defined -> steps at acceptance, +20, +28, +36, +44 (idx 0->5).
  - Macro undefined -> idx 1 only.
